bcd_updown_counter: RTL

Parametrised multi-digit modulo counter and the successor to the single-digit mod-10 counter. It provides DIGITS cascaded digits, each counting modulo MODULUS (BCD by default), with up/down direction, synchronous parallel load, enable, and wrap or saturate mode. Typical uses are timer, stopwatch and display-driver paths. Terminal-count and overflow outputs allow further instances to be chained.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit.sv | 39 +++
 rtl/bcd_updown_counter.sv | 73 +++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared widths and digit helpers for the multi-digit modulo counter.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    function automatic logic [DIGIT_W-1:0] digit_max(input int unsigned modulus);
        return DIGIT_W'(modulus - 1);
    endfunction

    // Out-of-range digit values saturate to the largest legal digit.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value,
                                                       input int unsigned modulus);
        if (32'(value) >= modulus) begin
            return digit_max(modulus);
        end
        return value;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One modulo-MODULUS digit: register, load clamp and up/down wrap.
module bcd_digit
    import bcd_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               step,
    input  logic               up,
    output logic [DIGIT_W-1:0] q,
    output logic               at_max,
    output logic               at_min
);

    localparam logic [DIGIT_W-1:0] MAX = digit_max(MODULUS);

    always_comb begin
        at_max = (q == MAX);
        at_min = (q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= clamp_digit(ld_val, MODULUS);
        end else if (step) begin
            if (up) begin
                q <= at_max ? '0 : q + DIGIT_W'(1);
            end else begin
                q <= at_min ? MAX : q - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded up/down modulo counter with load, wrap/saturate, tc and ovf.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned MODULUS  = 10,
    parameter int unsigned SATURATE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       up,
    input  logic                       load,
    input  logic [DIGIT_W*DIGITS-1:0]  load_val,
    output logic [DIGIT_W*DIGITS-1:0]  count,
    output logic                       tc,
    output logic                       ovf
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] chain;
    logic [DIGITS-1:0] step;
    logic              all_max;
    logic              all_min;
    logic              terminal;
    logic              advance;

    // Prefix AND of the lower digits' end flags gives each digit's step enable.
    always_comb begin
        logic acc_up;
        logic acc_dn;
        acc_up = 1'b1;
        acc_dn = 1'b1;
        chain  = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            chain[i] = up ? acc_up : acc_dn;
            acc_up   = acc_up & at_max[i];
            acc_dn   = acc_dn & at_min[i];
        end
        all_max  = acc_up;
        all_min  = acc_dn;
        terminal = up ? all_max : all_min;
        advance  = en && !load && !((SATURATE != 0) && terminal);
        step     = chain & {DIGITS{advance}};
        tc       = !rst && en && terminal;
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        bcd_digit #(
            .MODULUS (MODULUS)
        ) u_digit (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .ld_val (load_val[g*DIGIT_W +: DIGIT_W]),
            .step   (step[g]),
            .up     (up),
            .q      (count[g*DIGIT_W +: DIGIT_W]),
            .at_max (at_max[g]),
            .at_min (at_min[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= en && !load && terminal && (SATURATE == 0);
        end
    end

endmodule
